// File: rtl/mem_stage_ctrl_pkg.sv
// Shared types for the memory-stage controller: FSM states, op kinds and the
// decoder-flag priority function.
package mem_stage_ctrl_pkg;

    localparam int DEF_ADDR_W = 12;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    typedef enum logic [2:0] {
        OP_NONE  = 3'd0,
        OP_LOAD  = 3'd1,
        OP_LDM   = 3'd2,
        OP_STORE = 3'd3,
        OP_PUSH  = 3'd4,
        OP_POP   = 3'd5
    } op_kind_t;

    // When several flags are set the highest-priority one wins: push > pop > write > read.
    function automatic op_kind_t decode_op(input logic push, input logic pop,
                                           input logic wr, input logic rd,
                                           input logic imm);
        op_kind_t k;
        k = OP_NONE;
        if (push)     k = OP_PUSH;
        else if (pop) k = OP_POP;
        else if (wr)  k = OP_STORE;
        else if (rd)  k = imm ? OP_LDM : OP_LOAD;
        return k;
    endfunction

endpackage

// File: rtl/mem_stage_ctrl_stack_pointer_unit.sv
// Stack pointer register with wrap-around inc/dec strobes and a sticky underflow
// flag raised when a pop is accepted while the stack is empty.
module mem_stage_ctrl_stack_pointer_unit #(
    parameter int                ADDR_W  = 12,
    parameter logic [ADDR_W-1:0] SP_INIT = {ADDR_W{1'b1}}
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_inc,
    input  logic              i_dec,
    input  logic              i_pop_accept,
    output logic [ADDR_W-1:0] o_sp,
    output logic              o_underflow
);

    logic [ADDR_W-1:0] r_sp;
    logic              r_underflow;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_sp        <= SP_INIT;
            r_underflow <= 1'b0;
        end else begin
            if (i_inc)
                r_sp <= r_sp + ADDR_W'(1);
            else if (i_dec)
                r_sp <= r_sp - ADDR_W'(1);
            if (i_pop_accept && (r_sp == SP_INIT))
                r_underflow <= 1'b1;
        end
    end

    assign o_sp        = r_sp;
    assign o_underflow = r_underflow;

endmodule

// File: rtl/mem_stage_ctrl.sv
// Memory-stage controller: turns decoded control flags into data-memory
// transactions, owns the stack pointer and emits the registered write-back beat.
module mem_stage_ctrl
    import mem_stage_ctrl_pkg::*;
#(
    parameter int                DATA_W  = 16,
    parameter int                ADDR_W  = DEF_ADDR_W,
    parameter int                RD_W    = 3,
    parameter logic [ADDR_W-1:0] SP_INIT = {ADDR_W{1'b1}}
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              op_valid,
    input  logic              mem_read,
    input  logic              mem_write,
    input  logic              push_signal,
    input  logic              pop_signal,
    input  logic              immediate_signal,
    input  logic              wb_in,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [RD_W-1:0]   rd_in,
    output logic              stall,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ack,
    output logic              wb_valid,
    output logic [RD_W-1:0]   wb_rd,
    output logic [DATA_W-1:0] wb_data,
    output logic [ADDR_W-1:0] sp,
    output logic              stack_underflow,
    output state_t            dbg_state
);

    state_t            r_state;
    op_kind_t          r_kind;
    logic              r_mem_req;
    logic              r_mem_we;
    logic [ADDR_W-1:0] r_mem_addr;
    logic [DATA_W-1:0] r_mem_wdata;
    logic [DATA_W-1:0] r_rdata;
    logic [RD_W-1:0]   r_rd;
    logic              r_wb_valid;
    logic [RD_W-1:0]   r_wb_rd;
    logic [DATA_W-1:0] r_wb_data;

    op_kind_t          w_kind;
    logic              w_is_mem;
    logic              w_ack;
    logic [ADDR_W-1:0] w_sp;

    assign w_kind   = decode_op(push_signal, pop_signal, mem_write, mem_read, immediate_signal);
    assign w_is_mem = (w_kind == OP_LOAD) || (w_kind == OP_STORE) ||
                      (w_kind == OP_PUSH) || (w_kind == OP_POP);
    // Handshake: mem_req and all mem_* stay frozen until mem_ack is sampled high
    // on a clock edge while in REQ; ack in any other state is ignored.
    assign w_ack    = (r_state == ST_REQ) && mem_ack;

    mem_stage_ctrl_stack_pointer_unit #(
        .ADDR_W  (ADDR_W),
        .SP_INIT (SP_INIT)
    ) u_spu (
        .i_clk        (clk),
        .i_rst        (rst),
        .i_inc        (w_ack && (r_kind == OP_POP)),
        .i_dec        (w_ack && (r_kind == OP_PUSH)),
        .i_pop_accept ((r_state == ST_IDLE) && op_valid && (w_kind == OP_POP)),
        .o_sp         (w_sp),
        .o_underflow  (stack_underflow)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_kind      <= OP_NONE;
            r_mem_req   <= 1'b0;
            r_mem_we    <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
            r_rdata     <= '0;
            r_rd        <= '0;
            r_wb_valid  <= 1'b0;
            r_wb_rd     <= '0;
            r_wb_data   <= '0;
        end else begin
            r_wb_valid <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (op_valid && w_is_mem) begin
                        r_state     <= ST_REQ;
                        r_kind      <= w_kind;
                        r_mem_req   <= 1'b1;
                        r_mem_we    <= (w_kind == OP_PUSH) || (w_kind == OP_STORE);
                        r_mem_wdata <= wdata;
                        r_rd        <= rd_in;
                        if (w_kind == OP_PUSH)
                            r_mem_addr <= w_sp;
                        else if (w_kind == OP_POP)
                            r_mem_addr <= w_sp + ADDR_W'(1);
                        else
                            r_mem_addr <= addr;
                    end else if (op_valid && (wb_in || (w_kind == OP_LDM))) begin
                        r_wb_valid <= 1'b1;
                        r_wb_data  <= wdata;
                        r_wb_rd    <= rd_in;
                    end
                end
                ST_REQ: begin
                    if (mem_ack) begin
                        r_mem_req <= 1'b0;
                        r_rdata   <= mem_rdata;
                        r_state   <= r_mem_we ? ST_IDLE : ST_RESP;
                    end
                end
                ST_RESP: begin
                    r_wb_valid <= 1'b1;
                    r_wb_data  <= r_rdata;
                    r_wb_rd    <= r_rd;
                    r_state    <= ST_IDLE;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign stall     = (r_state != ST_IDLE);
    assign mem_req   = r_mem_req;
    assign mem_we    = r_mem_we;
    assign mem_addr  = r_mem_addr;
    assign mem_wdata = r_mem_wdata;
    assign wb_valid  = r_wb_valid;
    assign wb_rd     = r_wb_rd;
    assign wb_data   = r_wb_data;
    assign sp        = w_sp;
    assign dbg_state = r_state;

endmodule

// File: tb/tb_mem_stage_ctrl.sv
// Self-checking bench for mem_stage_ctrl: directed scenarios plus random ops
// compared against a transaction-level model of the stack, memory and write-back.
module tb_mem_stage_ctrl;

    localparam int DATA_W = 16;
    localparam int ADDR_W = 12;
    localparam int RD_W   = 3;
    localparam int SP_TOP = 4095;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              op_valid = 1'b0;
    logic              mem_read = 1'b0;
    logic              mem_write = 1'b0;
    logic              push_signal = 1'b0;
    logic              pop_signal = 1'b0;
    logic              immediate_signal = 1'b0;
    logic              wb_in = 1'b0;
    logic [ADDR_W-1:0] addr = '0;
    logic [DATA_W-1:0] wdata = '0;
    logic [RD_W-1:0]   rd_in = '0;
    logic              stall;
    logic              mem_req;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata = '0;
    logic              mem_ack = 1'b0;
    logic              wb_valid;
    logic [RD_W-1:0]   wb_rd;
    logic [DATA_W-1:0] wb_data;
    logic [ADDR_W-1:0] sp;
    logic              stack_underflow;
    mem_stage_ctrl_pkg::state_t dbg_state;

    mem_stage_ctrl dut (
        .clk(clk), .rst(rst), .op_valid(op_valid), .mem_read(mem_read),
        .mem_write(mem_write), .push_signal(push_signal), .pop_signal(pop_signal),
        .immediate_signal(immediate_signal), .wb_in(wb_in), .addr(addr),
        .wdata(wdata), .rd_in(rd_in), .stall(stall), .mem_req(mem_req),
        .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .mem_ack(mem_ack), .wb_valid(wb_valid),
        .wb_rd(wb_rd), .wb_data(wb_data), .sp(sp),
        .stack_underflow(stack_underflow), .dbg_state(dbg_state)
    );

    always #5 clk = ~clk;

    int                n_tests = 0;
    int                n_fail  = 0;
    int                m_sp    = SP_TOP;
    bit                m_uflow = 1'b0;
    logic [DATA_W-1:0] mem_model [int];
    logic [DATA_W-1:0] exp_q[$];

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
        end
    endtask

    // 0 none, 1 load, 2 ldm, 3 store, 4 push, 5 pop
    function automatic int classify(input bit push, input bit pop, input bit wr,
                                    input bit rdf, input bit imm);
        if (push) return 4;
        if (pop)  return 5;
        if (wr)   return 3;
        if (rdf)  return imm ? 2 : 1;
        return 0;
    endfunction

    task automatic set_op(input bit push, input bit pop, input bit wr, input bit rdf,
                          input bit imm, input bit wbi, input logic [ADDR_W-1:0] a,
                          input logic [DATA_W-1:0] d, input logic [RD_W-1:0] r);
        push_signal = push; pop_signal = pop; mem_write = wr; mem_read = rdf;
        immediate_signal = imm; wb_in = wbi; addr = a; wdata = d; rd_in = r;
        op_valid = 1'b1;
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_stall"}, stall, 0);
        check({tag, "_req"}, mem_req, 0);
        check({tag, "_we"}, mem_we, 0);
        check({tag, "_addr"}, mem_addr, 0);
        check({tag, "_wdata"}, mem_wdata, 0);
        check({tag, "_wbv"}, wb_valid, 0);
        check({tag, "_wbrd"}, wb_rd, 0);
        check({tag, "_wbdata"}, wb_data, 0);
        check({tag, "_sp"}, sp, SP_TOP);
        check({tag, "_uflow"}, stack_underflow, 0);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        op_valid = 1'b0;
        mem_ack = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        m_sp = SP_TOP;
        m_uflow = 1'b0;
    endtask

    // Drives one op at a negedge and follows it to completion; waits = ack delay cycles.
    task automatic do_op(input bit push, input bit pop, input bit wr, input bit rdf,
                         input bit imm, input bit wbi, input logic [ADDR_W-1:0] a,
                         input logic [DATA_W-1:0] d, input logic [RD_W-1:0] r,
                         input int waits);
        int                k;
        int                exp_addr;
        bit                exp_we;
        logic [DATA_W-1:0] rdv;
        k = classify(push, pop, wr, rdf, imm);
        rdv = '0;
        check("pre_stall", stall, 0);
        if (k == 5 && m_sp == SP_TOP) m_uflow = 1'b1;
        exp_addr = (k == 4) ? m_sp : (k == 5) ? (m_sp + 1) % 4096 : int'(a);
        exp_we = (k == 4) || (k == 3);
        set_op(push, pop, wr, rdf, imm, wbi, a, d, r);
        @(negedge clk);
        op_valid = 1'b0;
        if (k == 0 || k == 2) begin
            check("nm_stall", stall, 0);
            check("nm_req", mem_req, 0);
            if (wbi || k == 2) begin
                check("nm_wbv", wb_valid, 1);
                check("nm_wbdata", wb_data, d);
                check("nm_wbrd", wb_rd, r);
            end else begin
                check("nm_wbv", wb_valid, 0);
            end
        end else begin
            for (int w = 0; w <= waits; w++) begin
                check("req", mem_req, 1);
                check("req_stall", stall, 1);
                check("req_addr", mem_addr, exp_addr);
                check("req_we", mem_we, exp_we);
                if (exp_we) check("req_wdata", mem_wdata, d);
                check("req_wbv", wb_valid, 0);
                if (w == waits) begin
                    mem_ack = 1'b1;
                    if (!exp_we) begin
                        rdv = mem_model.exists(exp_addr) ? mem_model[exp_addr] : DATA_W'($urandom);
                        mem_model[exp_addr] = rdv;
                        mem_rdata = rdv;
                    end else begin
                        mem_rdata = DATA_W'($urandom);
                    end
                end else begin
                    mem_ack = 1'b0;
                    mem_rdata = DATA_W'($urandom);
                end
                @(negedge clk);
            end
            mem_ack = 1'b0;
            if (exp_we) mem_model[exp_addr] = d;
            if (k == 4) m_sp = (m_sp + 4095) % 4096;
            if (k == 5) m_sp = (m_sp + 1) % 4096;
            check("ack_req", mem_req, 0);
            check("ack_wbv", wb_valid, 0);
            if (exp_we) begin
                check("wr_stall", stall, 0);
            end else begin
                check("resp_stall", stall, 1);
                @(negedge clk);
                check("rd_wbv", wb_valid, 1);
                check("rd_wbdata", wb_data, rdv);
                check("rd_wbrd", wb_rd, r);
                check("rd_stall", stall, 0);
            end
        end
        check("sp", sp, m_sp);
        check("uflow", stack_underflow, m_uflow);
    endtask

    initial begin
        logic [DATA_W-1:0] seq_d [5];
        logic [RD_W-1:0]   seq_r [5];
        logic [DATA_W-1:0] exp_d;

        do_reset();
        check_reset_vals("rst");

        do_op(1, 0, 0, 0, 0, 0, 12'h000, 16'h1234, 3'd0, 2);
        check("push_sp", sp, 12'hFFE);
        do_op(0, 1, 0, 0, 0, 1, 12'h000, 16'h0000, 3'd3, 0);
        check("pop_wbdata", wb_data, 16'h1234);

        do_reset();
        do_op(0, 1, 0, 0, 0, 1, 12'h000, 16'h0000, 3'd1, 1);
        check("uflow_set", stack_underflow, 1);
        check("uflow_wrap_sp", sp, 12'h000);
        do_op(0, 0, 0, 0, 0, 0, 12'h000, 16'h0000, 3'd0, 0);
        check("uflow_sticky", stack_underflow, 1);

        mem_model[32'h020] = 16'hBEEF;
        do_op(0, 0, 0, 1, 0, 1, 12'h020, 16'h0000, 3'd5, 0);
        check("load_beef", wb_data, 16'hBEEF);
        do_op(0, 0, 1, 0, 0, 0, 12'h021, 16'h5A5A, 3'd2, 1);

        seq_d[0] = 16'h0001; seq_d[1] = 16'h0002; seq_d[2] = 16'h0003;
        seq_d[3] = 16'h0004; seq_d[4] = 16'h00FF;
        for (int i = 0; i < 5; i++) begin
            seq_r[i] = RD_W'($urandom);
            set_op(0, 0, 0, i == 4, i == 4, i != 4, 12'h000, seq_d[i], seq_r[i]);
            exp_q.push_back(seq_d[i]);
            @(negedge clk);
            exp_d = exp_q.pop_front();
            check("b2b_stall", stall, 0);
            check("b2b_wbv", wb_valid, 1);
            check("b2b_wbdata", wb_data, exp_d);
            check("b2b_wbrd", wb_rd, seq_r[i]);
        end
        op_valid = 1'b0;
        @(negedge clk);
        check("b2b_end_wbv", wb_valid, 0);

        do_op(1, 1, 0, 0, 0, 1, 12'h000, 16'hCAFE, 3'd4, 0);

        mem_ack = 1'b1;
        @(negedge clk);
        mem_ack = 1'b0;
        check("idle_ack_req", mem_req, 0);
        check("idle_ack_sp", sp, m_sp);
        check("idle_ack_stall", stall, 0);

        set_op(1, 0, 0, 0, 0, 0, 12'h000, 16'h7777, 3'd0);
        @(negedge clk);
        op_valid = 1'b0;
        check("midreq_req", mem_req, 1);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        check_reset_vals("midrst");
        rst = 1'b0;
        m_sp = SP_TOP;
        m_uflow = 1'b0;
        @(negedge clk);
        check("midrst_after_wbv", wb_valid, 0);
        check("midrst_after_req", mem_req, 0);

        for (int n = 0; n < 200; n++) begin
            if ($urandom_range(0, 9) == 0) begin
                mem_ack = 1'b1;
                @(negedge clk);
                mem_ack = 1'b0;
                check("rnd_idle_ack_req", mem_req, 0);
                check("rnd_idle_ack_sp", sp, m_sp);
            end
            do_op($urandom_range(0, 5) == 0, $urandom_range(0, 5) == 0,
                  $urandom_range(0, 4) == 0, $urandom_range(0, 2) == 0,
                  $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1,
                  ADDR_W'($urandom_range(0, 63)), DATA_W'($urandom),
                  RD_W'($urandom), $urandom_range(0, 3));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
